// File: rtl/commit_trace_unit_if.sv
// rtl/commit_trace_unit_if.sv - pipeline event taps and trace record stream for commit_trace_unit
interface commit_trace_unit_if;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        halt;
  logic        icache_req;
  logic        icache_hit;
  logic        dcache_req;
  logic        dcache_hit;
  logic        stall;
  logic        rec_valid;
  logic [39:0] rec_data;
  logic        rec_ready;
  logic        done;

  modport slave (
    input  reg_write, write_reg, write_data,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_rdata,
    input  halt, icache_req, icache_hit, dcache_req, dcache_hit,
    input  rec_ready,
    output stall, rec_valid, rec_data, done
  );

  modport master (
    output reg_write, write_reg, write_data,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_rdata,
    output halt, icache_req, icache_hit, dcache_req, dcache_hit,
    output rec_ready,
    input  stall, rec_valid, rec_data, done
  );
endinterface

// File: rtl/commit_trace_unit.sv
// rtl/commit_trace_unit.sv - encodes commit events into 40-bit trace records, buffers and streams them
module commit_trace_unit #(
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  commit_trace_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_SUMM,
    S_ENDR,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [39:0]     mem_q [DEPTH];
  logic [39:0]     mem_d [DEPTH];

  logic [31:0]     cycles_q, cycles_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     dhit_q, dhit_d;
  logic [31:0]     ihit_q, ihit_d;
  logic [31:0]     dreq_q, dreq_d;
  logic [31:0]     ireq_q, ireq_d;

  logic            stall;
  logic            sample;
  logic            pop;
  logic            has_space;
  logic            mem_ev;
  logic [39:0]     reg_rec;
  logic [39:0]     mem_rec;
  logic [31:0]     sum_val;
  logic [1:0]      n_push;
  logic [39:0]     push0_rec;
  logic [39:0]     push1_rec;

  // Stall looks only at registered state, so a same-cycle pop never frees a slot early.
  assign stall     = (state_q != S_RUN) || (count_q > CW'(DEPTH - 2));
  assign sample    = (state_q == S_RUN) && !stall;
  assign pop       = (count_q != '0) && bus.rec_ready;
  assign has_space = count_q < CW'(DEPTH);

  assign bus.stall     = stall;
  assign bus.rec_valid = (count_q != '0);
  assign bus.rec_data  = mem_q[rd_ptr_q];
  assign bus.done      = (state_q == S_DONE);

  // A simultaneous read and write is illegal upstream; the store wins.
  assign mem_ev  = bus.mem_read | bus.mem_write;
  assign reg_rec = {4'h1, 1'b0, bus.write_reg, 16'h0000, bus.write_data};
  assign mem_rec = bus.mem_write ? {4'h3, 4'h0, bus.mem_addr, bus.mem_wdata}
                                 : {4'h2, 4'h0, bus.mem_addr, bus.mem_rdata};

  always_comb begin
    sum_val = 32'h0;
    case (idx_q)
      3'd0:    sum_val = cycles_q;
      3'd1:    sum_val = inst_q;
      3'd2:    sum_val = dhit_q;
      3'd3:    sum_val = ihit_q;
      3'd4:    sum_val = dreq_q;
      3'd5:    sum_val = ireq_q;
      default: sum_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_push    = 2'd0;
    push0_rec = '0;
    push1_rec = '0;

    case (state_q)
      S_RUN: begin
        if (sample) begin
          if (bus.reg_write) begin
            push0_rec = reg_rec;
            if (mem_ev) begin
              push1_rec = mem_rec;
              n_push    = 2'd2;
            end else begin
              n_push    = 2'd1;
            end
          end else if (mem_ev) begin
            push0_rec = mem_rec;
            n_push    = 2'd1;
          end
          if (bus.halt) begin
            state_d = S_SUMM;
            idx_d   = 3'd0;
          end
        end
      end
      S_SUMM: begin
        if (has_space) begin
          push0_rec = {4'h4, 1'b0, idx_q, sum_val};
          n_push    = 2'd1;
          if (idx_q == 3'd5) begin
            state_d = S_ENDR;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_ENDR: begin
        if (has_space) begin
          push0_rec = {4'hF, 36'h0};
          n_push    = 2'd1;
          state_d   = S_DONE;
        end
      end
      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (n_push != 2'd0) begin
      mem_d[wr_ptr_q] = push0_rec;
    end
    if (n_push == 2'd2) begin
      mem_d[wr_ptr_q + AW'(1)] = push1_rec;
    end
    wr_ptr_d = wr_ptr_q + AW'(n_push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(n_push) - CW'(pop);
  end

  always_comb begin
    cycles_d = cycles_q;
    inst_d   = inst_q;
    dhit_d   = dhit_q;
    ihit_d   = ihit_q;
    dreq_d   = dreq_q;
    ireq_d   = ireq_q;
    if (state_q == S_RUN) begin
      cycles_d = cycles_q + 32'd1;
    end
    if (sample) begin
      if (bus.halt | bus.reg_write | bus.mem_write) inst_d = inst_q + 32'd1;
      if (bus.dcache_hit) dhit_d = dhit_q + 32'd1;
      if (bus.icache_hit) ihit_d = ihit_q + 32'd1;
      if (bus.dcache_req) dreq_d = dreq_q + 32'd1;
      if (bus.icache_req) ireq_d = ireq_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      idx_q    <= 3'd0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cycles_q <= 32'h0;
      inst_q   <= 32'h0;
      dhit_q   <= 32'h0;
      ihit_q   <= 32'h0;
      dreq_q   <= 32'h0;
      ireq_q   <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cycles_q <= cycles_d;
      inst_q   <= inst_d;
      dhit_q   <= dhit_d;
      ihit_q   <= ihit_d;
      dreq_q   <= dreq_d;
      ireq_q   <= ireq_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_commit_trace_unit.sv
// tb/tb_commit_trace_unit.sv - directed self-checking bench for commit_trace_unit
module tb_commit_trace_unit;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miss_cnt;

  commit_trace_unit_if bus ();

  commit_trace_unit #(.DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.reg_write  = 1'b0;
    bus.write_reg  = 3'd0;
    bus.write_data = 16'h0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = 16'h0;
    bus.mem_wdata  = 16'h0;
    bus.mem_rdata  = 16'h0;
    bus.halt       = 1'b0;
    bus.icache_req = 1'b0;
    bus.icache_hit = 1'b0;
    bus.dcache_req = 1'b0;
    bus.dcache_hit = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    bus.rec_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_reg_load(input int k);
    bus.reg_write  = 1'b1;
    bus.write_reg  = 3'd5;
    bus.write_data = 16'h1000 + 16'(k);
    bus.mem_read   = 1'b1;
    bus.mem_addr   = 16'h0100 + 16'(k);
    bus.mem_rdata  = 16'h2000 + 16'(k);
  endtask

  task automatic pop_one(output logic [39:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 64; i++) begin
      if (bus.rec_valid) begin
        d = bus.rec_data;
        bus.rec_ready = 1'b1;
        @(negedge clk);
        bus.rec_ready = 1'b0;
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [39:0] d;
    bit ok;
    clear_inputs();
    bus.rec_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus.rec_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_rec_valid got %0b want 0", bus.rec_valid); end
    vec_cnt++; if (bus.rec_data !== 40'h0) begin miss_cnt++; $display("FAIL reset_rec_data got %h want 0", bus.rec_data); end
    vec_cnt++; if (bus.stall !== 1'b0) begin miss_cnt++; $display("FAIL reset_stall got %0b want 0", bus.stall); end
    vec_cnt++; if (bus.done !== 1'b0) begin miss_cnt++; $display("FAIL reset_done got %0b want 0", bus.done); end
    rst_n = 1'b1;
    bus.halt = 1'b1;
    @(negedge clk);
    bus.halt = 1'b0;
    vec_cnt++; if (bus.stall !== 1'b1) begin miss_cnt++; $display("FAIL summ_stall got %0b want 1", bus.stall); end
    repeat (5) @(negedge clk);
    vec_cnt++; if (bus.rec_valid !== 1'b1) begin miss_cnt++; $display("FAIL summ_buffered got %0b want 1", bus.rec_valid); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (bus.rec_valid !== 1'b0) begin miss_cnt++; $display("FAIL async_rst_valid got %0b want 0", bus.rec_valid); end
    vec_cnt++; if (bus.done !== 1'b0) begin miss_cnt++; $display("FAIL async_rst_done got %0b want 0", bus.done); end
    vec_cnt++; if (bus.stall !== 1'b0) begin miss_cnt++; $display("FAIL async_rst_stall got %0b want 0", bus.stall); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.halt = 1'b1;
    @(negedge clk);
    bus.halt = 1'b0;
    pop_one(d, ok);
    vec_cnt++; if (!ok || d !== 40'h40_0000_0001) begin miss_cnt++; $display("FAIL post_rst_summ0 got %h ok=%0b want 4000000001", d, ok); end
    pop_one(d, ok);
    vec_cnt++; if (!ok || d !== 40'h41_0000_0001) begin miss_cnt++; $display("FAIL post_rst_summ1 got %h ok=%0b want 4100000001", d, ok); end
  endtask

  task automatic test_reg();
    do_reset();
    bus.reg_write  = 1'b1;
    bus.write_reg  = 3'd3;
    bus.write_data = 16'hBEEF;
    bus.rec_ready  = 1'b1;
    @(negedge clk);
    clear_inputs();
    vec_cnt++; if (bus.rec_valid !== 1'b1) begin miss_cnt++; $display("FAIL reg_valid got %0b want 1", bus.rec_valid); end
    vec_cnt++; if (bus.rec_data !== 40'h13_0000_BEEF) begin miss_cnt++; $display("FAIL reg_data got %h want 130000beef", bus.rec_data); end
    @(negedge clk);
    vec_cnt++; if (bus.rec_valid !== 1'b0) begin miss_cnt++; $display("FAIL reg_popped got %0b want 0", bus.rec_valid); end
    bus.rec_ready = 1'b0;
  endtask

  task automatic test_load();
    logic [39:0] d;
    bit ok;
    do_reset();
    bus.reg_write  = 1'b1;
    bus.write_reg  = 3'd5;
    bus.write_data = 16'h1234;
    bus.mem_read   = 1'b1;
    bus.mem_addr   = 16'h0040;
    bus.mem_rdata  = 16'h1234;
    @(negedge clk);
    clear_inputs();
    pop_one(d, ok);
    vec_cnt++; if (!ok || d !== 40'h15_0000_1234) begin miss_cnt++; $display("FAIL load_reg_rec got %h ok=%0b want 1500001234", d, ok); end
    pop_one(d, ok);
    vec_cnt++; if (!ok || d !== 40'h20_0040_1234) begin miss_cnt++; $display("FAIL load_mem_rec got %h ok=%0b want 2000401234", d, ok); end
    vec_cnt++; if (bus.rec_valid !== 1'b0) begin miss_cnt++; $display("FAIL load_drained got %0b want 0", bus.rec_valid); end
  endtask

  task automatic test_backpressure();
    logic [39:0] d;
    logic [39:0] exp_q [8];
    bit ok;
    for (int k = 1; k <= 4; k++) begin
      exp_q[2*(k-1)]   = {4'h1, 4'h5, 16'h0000, 16'h1000 + 16'(k)};
      exp_q[2*(k-1)+1] = {4'h2, 4'h0, 16'h0100 + 16'(k), 16'h2000 + 16'(k)};
    end
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive_reg_load(k);
      @(negedge clk);
    end
    vec_cnt++; if (bus.stall !== 1'b0) begin miss_cnt++; $display("FAIL bp_count6_stall got %0b want 0", bus.stall); end
    drive_reg_load(4);
    @(negedge clk);
    vec_cnt++; if (bus.stall !== 1'b1) begin miss_cnt++; $display("FAIL bp_count8_stall got %0b want 1", bus.stall); end
    @(negedge clk);
    vec_cnt++; if (bus.stall !== 1'b1) begin miss_cnt++; $display("FAIL bp_held_stall got %0b want 1", bus.stall); end
    pop_one(d, ok);
    vec_cnt++; if (!ok || d !== exp_q[0]) begin miss_cnt++; $display("FAIL bp_pop0 got %h ok=%0b want %h", d, ok, exp_q[0]); end
    vec_cnt++; if (bus.stall !== 1'b1) begin miss_cnt++; $display("FAIL bp_pop1_stall got %0b want 1", bus.stall); end
    pop_one(d, ok);
    vec_cnt++; if (!ok || d !== exp_q[1]) begin miss_cnt++; $display("FAIL bp_pop1 got %h ok=%0b want %h", d, ok, exp_q[1]); end
    vec_cnt++; if (bus.stall !== 1'b0) begin miss_cnt++; $display("FAIL bp_pop2_stall got %0b want 0", bus.stall); end
    clear_inputs();
    for (int i = 2; i < 8; i++) begin
      pop_one(d, ok);
      vec_cnt++; if (!ok || d !== exp_q[i]) begin miss_cnt++; $display("FAIL bp_drain%0d got %h ok=%0b want %h", i, d, ok, exp_q[i]); end
    end
    vec_cnt++; if (bus.rec_valid !== 1'b0) begin miss_cnt++; $display("FAIL bp_no_extra got %0b want 0", bus.rec_valid); end
  endtask

  task automatic test_halt_summary();
    logic [39:0] d;
    logic [39:0] exp_q [10];
    bit ok;
    exp_q[0] = 40'h11_0000_0011;
    exp_q[1] = 40'h12_0000_0022;
    exp_q[2] = 40'h30_0080_5555;
    exp_q[3] = 40'h40_0000_000A;
    exp_q[4] = 40'h41_0000_0004;
    exp_q[5] = 40'h42_0000_0002;
    exp_q[6] = 40'h43_0000_000A;
    exp_q[7] = 40'h44_0000_0003;
    exp_q[8] = 40'h45_0000_000A;
    exp_q[9] = 40'hF0_0000_0000;
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      clear_inputs();
      bus.icache_req = 1'b1;
      bus.icache_hit = 1'b1;
      case (e)
        1: begin bus.reg_write = 1'b1; bus.write_reg = 3'd1; bus.write_data = 16'h0011; end
        2: begin bus.dcache_req = 1'b1; bus.dcache_hit = 1'b1; end
        3: begin bus.reg_write = 1'b1; bus.write_reg = 3'd2; bus.write_data = 16'h0022;
                 bus.dcache_req = 1'b1; bus.dcache_hit = 1'b1; end
        5: begin bus.mem_write = 1'b1; bus.mem_addr = 16'h0080; bus.mem_wdata = 16'h5555;
                 bus.dcache_req = 1'b1; end
        10: bus.halt = 1'b1;
        default: ;
      endcase
      @(negedge clk);
    end
    clear_inputs();
    vec_cnt++; if (bus.done !== 1'b0) begin miss_cnt++; $display("FAIL halt_done_early got %0b want 0", bus.done); end
    vec_cnt++; if (bus.stall !== 1'b1) begin miss_cnt++; $display("FAIL halt_stall got %0b want 1", bus.stall); end
    for (int i = 0; i < 10; i++) begin
      pop_one(d, ok);
      vec_cnt++; if (!ok || d !== exp_q[i]) begin miss_cnt++; $display("FAIL halt_rec%0d got %h ok=%0b want %h", i, d, ok, exp_q[i]); end
    end
    vec_cnt++; if (bus.done !== 1'b1) begin miss_cnt++; $display("FAIL halt_done got %0b want 1", bus.done); end
    vec_cnt++; if (bus.rec_valid !== 1'b0) begin miss_cnt++; $display("FAIL halt_drained got %0b want 0", bus.rec_valid); end
  endtask

  task automatic test_halt_full();
    logic [39:0] d;
    logic [39:0] exp_q [14];
    bit ok;
    for (int k = 1; k <= 3; k++) begin
      exp_q[2*(k-1)]   = {4'h1, 4'h5, 16'h0000, 16'h1000 + 16'(k)};
      exp_q[2*(k-1)+1] = {4'h2, 4'h0, 16'h0100 + 16'(k), 16'h2000 + 16'(k)};
    end
    exp_q[6]  = 40'h17_0000_7777;
    exp_q[7]  = 40'h40_0000_0004;
    exp_q[8]  = 40'h41_0000_0004;
    exp_q[9]  = 40'h42_0000_0000;
    exp_q[10] = 40'h43_0000_0000;
    exp_q[11] = 40'h44_0000_0000;
    exp_q[12] = 40'h45_0000_0000;
    exp_q[13] = 40'hF0_0000_0000;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive_reg_load(k);
      @(negedge clk);
    end
    clear_inputs();
    vec_cnt++; if (bus.stall !== 1'b0) begin miss_cnt++; $display("FAIL full_pre_halt_stall got %0b want 0", bus.stall); end
    bus.reg_write  = 1'b1;
    bus.write_reg  = 3'd7;
    bus.write_data = 16'h7777;
    bus.halt       = 1'b1;
    @(negedge clk);
    bus.write_reg  = 3'd1;
    bus.write_data = 16'hDEAD;
    bus.mem_write  = 1'b1;
    bus.mem_addr   = 16'hFFFF;
    bus.dcache_req = 1'b1;
    bus.dcache_hit = 1'b1;
    bus.icache_req = 1'b1;
    bus.icache_hit = 1'b1;
    for (int i = 0; i < 14; i++) begin
      pop_one(d, ok);
      vec_cnt++; if (!ok || d !== exp_q[i]) begin miss_cnt++; $display("FAIL full_rec%0d got %h ok=%0b want %h", i, d, ok, exp_q[i]); end
    end
    repeat (2) @(negedge clk);
    vec_cnt++; if (bus.done !== 1'b1) begin miss_cnt++; $display("FAIL full_done got %0b want 1", bus.done); end
    vec_cnt++; if (bus.rec_valid !== 1'b0) begin miss_cnt++; $display("FAIL full_no_extra got %0b want 0", bus.rec_valid); end
    clear_inputs();
  endtask

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    test_reset();
    test_reg();
    test_load();
    test_backpressure();
    test_halt_summary();
    test_halt_full();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
